// File: rtl/mst_fifo_mch_ctl_if.sv
`default_nettype none
// ============================================================================
// Module : mst_fifo_mch_ctl_if
// Desc   : Writer/reader/SRAM bus bundle for the multi-channel FIFO controller
// Rev    : 1.0  initial release
// ============================================================================
interface mst_fifo_mch_ctl_if #(
  parameter int NCH = 4,
  parameter int CAW = 12,
  parameter int DW  = 36
);
  localparam int CW = $clog2(NCH);
  localparam int AW = CAW + CW;

  logic           mltcn;
  logic           fifowr;
  logic [CW-1:0]  fifowrid;
  logic [DW-1:0]  fifo_din;
  logic           fiford;
  logic [CW-1:0]  fifordid;
  logic [DW-1:0]  fifo_dout;
  logic           fifo_dvld;
  logic [NCH-1:0] fifo_flush;
  logic [NCH-1:0] fifoafull;
  logic [NCH-1:0] fifonempt;
  logic [NCH-1:0] fifoovf;
  logic           mem_we;
  logic [AW-1:0]  mem_wa;
  logic [DW-1:0]  mem_d;
  logic           mem_re;
  logic [AW-1:0]  mem_ra;
  logic [DW-1:0]  mem_q;

  // Controller side
  modport slave (
    input  mltcn, fifowr, fifowrid, fifo_din, fiford, fifordid, fifo_flush, mem_q,
    output fifo_dout, fifo_dvld, fifoafull, fifonempt, fifoovf,
    output mem_we, mem_wa, mem_d, mem_re, mem_ra
  );

  // Environment side: FIFO writer/reader plus SRAM macro
  modport master (
    output mltcn, fifowr, fifowrid, fifo_din, fiford, fifordid, fifo_flush, mem_q,
    input  fifo_dout, fifo_dvld, fifoafull, fifonempt, fifoovf,
    input  mem_we, mem_wa, mem_d, mem_re, mem_ra
  );
endinterface
`default_nettype wire

// File: rtl/mst_fifo_mch_ctl.sv
`default_nettype none
// ============================================================================
// Module : mst_fifo_mch_ctl
// Desc   : NCH circular FIFOs in one simple-dual-port SRAM (FT60x master path)
// Rev    : 1.0  initial release
// ============================================================================
module mst_fifo_mch_ctl #(
  parameter int NCH       = 4,
  parameter int CAW       = 12,
  parameter int DW        = 36,
  parameter int AFULL_GAP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mst_fifo_mch_ctl_if.slave bus
);
  localparam int          CW         = $clog2(NCH);
  localparam int          AW         = CAW + CW;
  localparam int          CD         = 1 << CAW;
  localparam logic [AW:0] DEPTH_MCH  = (AW+1)'(CD);
  localparam logic [AW:0] DEPTH_POOL = (AW+1)'(NCH * CD);
  localparam logic [AW:0] GAP        = (AW+1)'(AFULL_GAP);

  logic           r_mltcn;
  logic           w_mode_chg;
  logic [AW:0]    w_depth;
  logic [AW:0]    w_afull_th;
  logic [CW-1:0]  w_wid;
  logic [CW-1:0]  w_rid;
  logic [AW-1:0]  w_wptr [NCH];
  logic [AW-1:0]  w_rptr [NCH];
  logic [NCH-1:0] w_wr_acc;
  logic [NCH-1:0] w_rd_acc;
  logic [NCH-1:0] w_afull;
  logic [NCH-1:0] w_nempt;
  logic [NCH-1:0] w_ovf;
  logic [AW-1:0]  w_wa;
  logic [AW-1:0]  w_ra;

  logic           r_mem_we;
  logic           r_mem_re;
  logic           r_rd_d1;
  logic           r_dvld;
  logic [AW-1:0]  r_mem_wa;
  logic [AW-1:0]  r_mem_ra;
  logic [DW-1:0]  r_mem_d;
  logic [DW-1:0]  r_dout;

  // A mode toggle acts as a flush of every channel and swallows that cycle's accesses
  assign w_mode_chg = bus.mltcn ^ r_mltcn;
  assign w_depth    = bus.mltcn ? DEPTH_MCH : DEPTH_POOL;
  assign w_afull_th = w_depth - GAP;
  assign w_wid      = bus.mltcn ? bus.fifowrid : '0;
  assign w_rid      = bus.mltcn ? bus.fifordid : '0;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam bit IS_CH0 = (c == 0);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          r_afull;
    logic          r_nempt;
    logic          r_ovf;
    logic [AW:0]   w_cnt_nxt;
    logic          w_flush;
    logic          w_active;
    logic          w_wr_hit;
    logic          w_rd_hit;
    logic          w_wr_ok;
    logic          w_rd_ok;

    assign w_flush  = bus.fifo_flush[c] | w_mode_chg;
    assign w_active = bus.mltcn | IS_CH0;
    assign w_wr_hit = bus.fifowr & (w_wid == CW'(c)) & ~w_flush;
    assign w_rd_hit = bus.fiford & (w_rid == CW'(c)) & ~w_flush;
    // Both strobes are judged on the pre-cycle count
    assign w_wr_ok  = w_wr_hit & (r_cnt != w_depth);
    assign w_rd_ok  = w_rd_hit & (r_cnt != '0);

    assign w_wr_acc[c] = w_wr_ok;
    assign w_rd_acc[c] = w_rd_ok;
    assign w_wptr[c]   = r_wptr;
    assign w_rptr[c]   = r_rptr;
    assign w_afull[c]  = r_afull;
    assign w_nempt[c]  = r_nempt;
    assign w_ovf[c]    = r_ovf;

    always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_flush) begin
        w_cnt_nxt = '0;
      end else if (w_wr_ok && !w_rd_ok) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end else if (!w_wr_ok && w_rd_ok) begin
        w_cnt_nxt = r_cnt - 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_cnt   <= '0;
        r_afull <= 1'b0;
        r_nempt <= 1'b0;
        r_ovf   <= 1'b0;
      end else begin
        r_cnt   <= w_cnt_nxt;
        r_nempt <= w_active & (w_cnt_nxt != '0);
        r_afull <= w_active & (w_cnt_nxt >= w_afull_th);
        if (w_flush) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_ovf  <= 1'b0;
        end else begin
          if (w_wr_ok)  r_wptr <= r_wptr + 1'b1;
          if (w_rd_ok)  r_rptr <= r_rptr + 1'b1;
          if (w_wr_hit && !w_wr_ok) r_ovf <= w_active;
        end
      end
    end
  end

  // Pool mode uses the full pointer; channel mode keeps the low CAW bits in its slice
  assign w_wa = bus.mltcn ? {w_wid, w_wptr[w_wid][CAW-1:0]} : w_wptr[0];
  assign w_ra = bus.mltcn ? {w_rid, w_rptr[w_rid][CAW-1:0]} : w_rptr[0];

  // r_mltcn resets to channel mode, so coming out of reset in pool mode flushes once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mltcn  <= 1'b1;
      r_mem_we <= 1'b0;
      r_mem_wa <= '0;
      r_mem_d  <= '0;
      r_mem_re <= 1'b0;
      r_mem_ra <= '0;
      r_rd_d1  <= 1'b0;
      r_dvld   <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_mltcn  <= bus.mltcn;
      r_mem_we <= |w_wr_acc;
      if (|w_wr_acc) begin
        r_mem_wa <= w_wa;
        r_mem_d  <= bus.fifo_din;
      end
      r_mem_re <= |w_rd_acc;
      if (|w_rd_acc) begin
        r_mem_ra <= w_ra;
      end
      r_rd_d1 <= r_mem_re;
      r_dvld  <= r_rd_d1;
      if (r_rd_d1) begin
        r_dout <= bus.mem_q;
      end
    end
  end

  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wa    = r_mem_wa;
  assign bus.mem_d     = r_mem_d;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_ra    = r_mem_ra;
  assign bus.fifo_dvld = r_dvld;
  assign bus.fifo_dout = r_dout;
  assign bus.fifoafull = w_afull;
  assign bus.fifonempt = w_nempt;
  assign bus.fifoovf   = w_ovf;
endmodule
`default_nettype wire
